// File: rtl/instr_slot_sequencer_if.sv
// Bundle between the instruction FIFOs, the execution units and the slot sequencer.
//
// Handshake: q_re pops one slot from all three queues only when q_empty is 0
// in the same cycle; the popped words appear on *_dat in the following cycle.
// Each *_valid is a one-cycle strobe qualifying *_issue; units have no ready
// and must accept the word in that cycle. dma_done is a one-cycle completion pulse.
interface instr_slot_sequencer_if #(
  parameter int DMA_W   = 78,
  parameter int CACHE_W = 17,
  parameter int OUT_W   = 3
);
  logic               q_empty;
  logic               q_re;
  logic [DMA_W-1:0]   dma_dat;
  logic               arith_dat;
  logic [CACHE_W-1:0] cache_dat;
  logic               dma_done;
  logic               cache_busy;
  logic [DMA_W-1:0]   dma_issue;
  logic               dma_valid;
  logic               arith_issue;
  logic               arith_valid;
  logic [CACHE_W-1:0] cache_issue;
  logic               cache_valid;
  logic [OUT_W-1:0]   dma_outstanding;
  logic [15:0]        slots_issued;
  logic               busy;
  logic [1:0]         dbg_state;

  modport slave (
    input  q_empty, dma_dat, arith_dat, cache_dat, dma_done, cache_busy,
    output q_re, dma_issue, dma_valid, arith_issue, arith_valid,
           cache_issue, cache_valid, dma_outstanding, slots_issued, busy, dbg_state
  );

  modport master (
    output q_empty, dma_dat, arith_dat, cache_dat, dma_done, cache_busy,
    input  q_re, dma_issue, dma_valid, arith_issue, arith_valid,
           cache_issue, cache_valid, dma_outstanding, slots_issued, busy, dbg_state
  );
endinterface

// File: rtl/instr_slot_sequencer.sv
// Pops one lockstep slot (DMA, arithmetic, cache) at a time, holds it until
// the DMA/cache ordering hazards clear, then issues all three words together.
module instr_slot_sequencer #(
  parameter int DMA_W       = 78,
  parameter int CACHE_W     = 17,
  parameter int MAX_DMA_OUT = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  instr_slot_sequencer_if.slave       bus
);
  localparam int OUT_W = $clog2(MAX_DMA_OUT + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FETCH = 2'd1, S_HOLD = 2'd2} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_q_re;

  logic [DMA_W-1:0]   r_dma_slot;
  logic               r_arith_slot;
  logic [CACHE_W-1:0] r_cache_slot;

  logic [DMA_W-1:0]   r_dma_issue;
  logic               r_dma_valid;
  logic               r_arith_issue;
  logic               r_arith_valid;
  logic [CACHE_W-1:0] r_cache_issue;
  logic               r_cache_valid;

  logic [OUT_W-1:0]   r_dma_out;
  logic [15:0]        r_slots;

  logic w_dma_active;
  logic w_cache_load;
  logic w_load_block;
  logic w_dma_block;
  logic w_issue;
  logic w_inc;
  logic w_dec;

  assign w_dma_active = r_dma_slot[DMA_W-1];
  assign w_cache_load = r_cache_slot[CACHE_W-1] & r_cache_slot[CACHE_W-2];

  // A load may go once the in-flight DMA count is effectively zero, which
  // includes the last transfer completing in this very cycle.
  assign w_load_block = w_cache_load & (r_dma_out != '0) &
                        ~((r_dma_out == OUT_W'(1)) & bus.dma_done);
  assign w_dma_block  = w_dma_active &
                        (bus.cache_busy | (r_dma_out == OUT_W'(MAX_DMA_OUT)));
  assign w_issue      = (r_state == S_HOLD) & ~(w_load_block | w_dma_block);

  assign w_inc = w_issue & w_dma_active;
  assign w_dec = bus.dma_done & (r_dma_out != '0);

  // Next-state and queue pop decode.
  always_comb begin
    w_state_nxt = r_state;
    w_q_re      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!bus.q_empty) begin
          w_q_re      = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: w_state_nxt = S_HOLD;
      S_HOLD: begin
        if (w_issue) begin
          if (!bus.q_empty) begin
            w_q_re      = 1'b1;
            w_state_nxt = S_FETCH;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Slot registers load from the queue outputs in the cycle after the pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dma_slot   <= '0;
      r_arith_slot <= 1'b0;
      r_cache_slot <= '0;
    end else if (r_state == S_FETCH) begin
      r_dma_slot   <= bus.dma_dat;
      r_arith_slot <= bus.arith_dat;
      r_cache_slot <= bus.cache_dat;
    end
  end

  // Issue registers: words hold their last value, strobes pulse once per slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dma_issue   <= '0;
      r_dma_valid   <= 1'b0;
      r_arith_issue <= 1'b0;
      r_arith_valid <= 1'b0;
      r_cache_issue <= '0;
      r_cache_valid <= 1'b0;
    end else begin
      r_dma_valid   <= w_issue & w_dma_active;
      r_arith_valid <= w_issue & r_arith_slot;
      r_cache_valid <= w_issue & r_cache_slot[CACHE_W-1];
      if (w_issue) begin
        r_dma_issue   <= r_dma_slot;
        r_arith_issue <= r_arith_slot;
        r_cache_issue <= r_cache_slot;
      end
    end
  end

  // In-flight DMA count; a simultaneous issue and completion cancel out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dma_out <= '0;
    end else begin
      case ({w_inc, w_dec})
        2'b10:   r_dma_out <= r_dma_out + OUT_W'(1);
        2'b01:   r_dma_out <= r_dma_out - OUT_W'(1);
        default: r_dma_out <= r_dma_out;
      endcase
    end
  end

  // Issued-slot counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       r_slots <= '0;
    else if (w_issue) r_slots <= r_slots + 16'd1;
  end

  assign bus.q_re            = w_q_re;
  assign bus.dma_issue       = r_dma_issue;
  assign bus.dma_valid       = r_dma_valid;
  assign bus.arith_issue     = r_arith_issue;
  assign bus.arith_valid     = r_arith_valid;
  assign bus.cache_issue     = r_cache_issue;
  assign bus.cache_valid     = r_cache_valid;
  assign bus.dma_outstanding = r_dma_out;
  assign bus.slots_issued    = r_slots;
  assign bus.busy            = (r_state != S_IDLE) | (r_dma_out != '0);
  assign bus.dbg_state       = r_state;
endmodule

// File: tb/tb_instr_slot_sequencer.sv
// Bench for instr_slot_sequencer: a queue driver, a slot-timing reference
// model checked every cycle, and directed scenarios plus a random program.
module tb_instr_slot_sequencer;
  localparam int DMA_W   = 78;
  localparam int CACHE_W = 17;
  localparam int MAX_OUT = 4;
  localparam int OUT_W   = 3;

  logic clk;
  logic reset;

  instr_slot_sequencer_if #(.DMA_W(DMA_W), .CACHE_W(CACHE_W), .OUT_W(OUT_W)) bus ();

  instr_slot_sequencer #(.DMA_W(DMA_W), .CACHE_W(CACHE_W), .MAX_DMA_OUT(MAX_OUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // program memory behind the queues
  logic [DMA_W-1:0]   dma_prog   [64];
  logic               arith_prog [64];
  logic [CACHE_W-1:0] cache_prog [64];
  int prog_len = 0;
  int rd_ptr   = 0;
  bit pop_pend = 0;

  // stimulus knobs
  int cyc = 0;
  int done_at[$];
  bit auto_done = 0;
  bit force_done_once = 0;
  bit force_busy = 0;
  int rand_done_pct = 0;
  int rand_busy_pct = 0;
  bit order_on = 0;
  logic [2:0] exp_q[$];

  // reference model of slot timing
  bit   m_pend;
  int   m_idx, m_elig, m_next, m_out;
  logic [15:0]        m_slots;
  logic [DMA_W-1:0]   e_dma_issue;
  logic               e_dma_valid, e_arith_issue, e_arith_valid, e_cache_valid;
  logic [CACHE_W-1:0] e_cache_issue;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [DMA_W-1:0] rnd_dma();
    logic [DMA_W-1:0] w;
    w[31:0]  = $urandom();
    w[63:32] = $urandom();
    w[77:64] = 14'($urandom());
    return w;
  endfunction

  task automatic add_slot(input bit da, input bit ar, input bit ca, input bit cl);
    logic [DMA_W-1:0]   d;
    logic [CACHE_W-1:0] c;
    d = rnd_dma();
    d[DMA_W-1] = da;
    c = CACHE_W'($urandom());
    c[CACHE_W-1] = ca;
    c[CACHE_W-2] = cl;
    dma_prog[prog_len]   = d;
    arith_prog[prog_len] = ar;
    cache_prog[prog_len] = c;
    prog_len++;
  endtask

  // Stall rules stated on the model's own count.
  function automatic bit blocked(input int idx, input int out_n, input bit done, input bit cb);
    int eff;
    eff = out_n - ((done && out_n > 0) ? 1 : 0);
    blocked = 1'b0;
    if (cache_prog[idx][CACHE_W-1] && cache_prog[idx][CACHE_W-2] && eff != 0) blocked = 1'b1;
    if (dma_prog[idx][DMA_W-1] && (cb || out_n >= MAX_OUT)) blocked = 1'b1;
  endfunction

  task automatic model_reset();
    m_pend = 0; m_idx = 0; m_elig = 0; m_next = 0; m_out = 0; m_slots = '0;
    e_dma_issue = '0; e_dma_valid = 0; e_arith_issue = 0; e_arith_valid = 0;
    e_cache_issue = '0; e_cache_valid = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_q_re"},   bus.q_re, 0);
    chk({tag, "_dv"},     bus.dma_valid, 0);
    chk({tag, "_av"},     bus.arith_valid, 0);
    chk({tag, "_cv"},     bus.cache_valid, 0);
    chk({tag, "_di"},     bus.dma_issue, 0);
    chk({tag, "_ai"},     bus.arith_issue, 0);
    chk({tag, "_ci"},     bus.cache_issue, 0);
    chk({tag, "_out"},    bus.dma_outstanding, 0);
    chk({tag, "_slots"},  bus.slots_issued, 0);
    chk({tag, "_busy"},   bus.busy, 0);
  endtask

  // Compare this cycle's outputs, then advance the model across the next edge.
  task automatic model_step();
    bit issue_now, pop_now, inc, dec;
    logic [2:0] mask;
    chk("dma_valid",   bus.dma_valid, e_dma_valid);
    chk("arith_valid", bus.arith_valid, e_arith_valid);
    chk("cache_valid", bus.cache_valid, e_cache_valid);
    chk("dma_issue",   bus.dma_issue, e_dma_issue);
    chk("arith_issue", bus.arith_issue, e_arith_issue);
    chk("cache_issue", bus.cache_issue, e_cache_issue);
    chk("slots",       bus.slots_issued, m_slots);
    chk("outstanding", bus.dma_outstanding, 128'(m_out));
    chk("busy",        bus.busy, (m_pend || m_out != 0));
    issue_now = m_pend && (cyc >= m_elig) && !blocked(m_idx, m_out, bus.dma_done, bus.cache_busy);
    pop_now   = !bus.q_empty && (!m_pend || issue_now);
    chk("q_re", bus.q_re, pop_now);
    mask = {bus.arith_valid, bus.cache_valid, bus.dma_valid};
    if (order_on && mask != 3'b000) begin
      if (exp_q.size() == 0) chk("order_extra", mask, 0);
      else                   chk("order", mask, exp_q.pop_front());
    end
    inc = issue_now && dma_prog[m_idx][DMA_W-1];
    dec = bus.dma_done && m_out > 0;
    m_out = m_out + int'(inc) - int'(dec);
    e_dma_valid = 0; e_arith_valid = 0; e_cache_valid = 0;
    if (issue_now) begin
      e_dma_issue   = dma_prog[m_idx];
      e_arith_issue = arith_prog[m_idx];
      e_cache_issue = cache_prog[m_idx];
      e_dma_valid   = dma_prog[m_idx][DMA_W-1];
      e_arith_valid = arith_prog[m_idx];
      e_cache_valid = cache_prog[m_idx][CACHE_W-1];
      m_slots++;
      m_pend = 0;
    end
    if (pop_now) begin
      m_pend = 1; m_idx = m_next; m_next++; m_elig = cyc + 2;
    end
  endtask

  // driver: one clock cycle of queue data and unit feedback
  task automatic tick();
    logic d, b;
    @(posedge clk); #1;
    cyc++;
    if (pop_pend) begin
      bus.dma_dat   = dma_prog[rd_ptr];
      bus.arith_dat = arith_prog[rd_ptr];
      bus.cache_dat = cache_prog[rd_ptr];
      rd_ptr++;
    end else begin
      bus.dma_dat   = rnd_dma();
      bus.arith_dat = 1'($urandom());
      bus.cache_dat = CACHE_W'($urandom());
    end
    bus.q_empty = (rd_ptr >= prog_len);
    d = force_done_once || (int'($urandom_range(99)) < rand_done_pct);
    if (auto_done && done_at.size() > 0 && done_at[0] == cyc) begin
      d = 1'b1;
      void'(done_at.pop_front());
    end
    force_done_once = 0;
    b = force_busy || (int'($urandom_range(99)) < rand_busy_pct);
    bus.dma_done   = d;
    bus.cache_busy = b;
    @(negedge clk);
    model_step();
    if (auto_done && bus.dma_valid) done_at.push_back(cyc + 3);
    pop_pend = bus.q_re;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    bus.q_empty = 1'b1; bus.dma_done = 1'b0; bus.cache_busy = 1'b0;
    bus.dma_dat = '0; bus.arith_dat = 1'b0; bus.cache_dat = '0;
    pop_pend = 0; rd_ptr = 0; done_at.delete();
    auto_done = 0; force_done_once = 0; force_busy = 0;
    rand_done_pct = 0; rand_busy_pct = 0; order_on = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_zero("rst");
    reset = 1'b1;
  endtask

  initial begin
    // reset and empty queue
    prog_len = 0;
    apply_reset();
    run(12);
    chk("empty_busy", bus.busy, 0);

    // five-slot relu program
    prog_len = 0;
    add_slot(1, 0, 0, 0);
    add_slot(0, 0, 1, 1);
    add_slot(0, 1, 0, 0);
    add_slot(0, 0, 1, 0);
    add_slot(1, 0, 0, 0);
    apply_reset();
    auto_done = 1; order_on = 1;
    exp_q = '{3'b001, 3'b010, 3'b100, 3'b010, 3'b001};
    run(30);
    chk("relu_slots", bus.slots_issued, 5);
    chk("relu_out", bus.dma_outstanding, 0);
    chk("relu_order_left", 128'(exp_q.size()), 0);

    // outstanding cap
    prog_len = 0;
    for (int i = 0; i < 6; i++) add_slot(1, 0, 0, 0);
    apply_reset();
    run(20);
    chk("cap_out", bus.dma_outstanding, 4);
    chk("cap_slots", bus.slots_issued, 4);
    force_done_once = 1;
    run(3);
    chk("cap_slot5", bus.slots_issued, 5);
    chk("cap_out_back", bus.dma_outstanding, 4);
    rand_done_pct = 100;
    run(15);
    chk("cap_drain_slots", bus.slots_issued, 6);
    chk("cap_drain_out", bus.dma_outstanding, 0);

    // simultaneous increment/decrement, and done at zero
    prog_len = 0;
    for (int i = 0; i < 3; i++) add_slot(1, 0, 0, 0);
    apply_reset();
    run(6);
    force_busy = 1;
    run(4);
    chk("sim_out_pre", bus.dma_outstanding, 2);
    force_busy = 0; force_done_once = 1;
    run(1);
    run(1);
    chk("sim_out", bus.dma_outstanding, 2);
    chk("sim_slots", bus.slots_issued, 3);
    force_done_once = 1; run(1);
    force_done_once = 1; run(1);
    force_done_once = 1; run(1);
    run(1);
    chk("done_at_zero", bus.dma_outstanding, 0);

    // cache_busy block
    prog_len = 0;
    add_slot(1, 0, 0, 0);
    add_slot(0, 1, 0, 0);
    apply_reset();
    auto_done = 1;
    run(2);
    force_busy = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("cb_no_dv", bus.dma_valid, 0);
      chk("cb_no_qre", bus.q_re, 0);
    end
    force_busy = 0;
    run(2);
    chk("cb_issue", bus.dma_valid, 1);
    run(12);
    chk("cb_slots", bus.slots_issued, 2);

    // reset mid-HOLD
    prog_len = 0;
    add_slot(1, 0, 0, 0);
    add_slot(0, 0, 1, 1);
    apply_reset();
    run(8);
    chk("mid_slots_pre", bus.slots_issued, 1);
    #2;
    reset = 1'b0;
    #1;
    chk_zero("midrst");
    prog_len = 0;
    apply_reset();
    run(10);
    chk("mid_slots_post", bus.slots_issued, 0);

    // random program with random feedback
    prog_len = 0;
    for (int i = 0; i < 40; i++)
      add_slot(1'($urandom()), 1'($urandom()), 1'($urandom()), 1'($urandom()));
    apply_reset();
    rand_done_pct = 25; rand_busy_pct = 25;
    run(300);
    rand_busy_pct = 0; rand_done_pct = 100;
    run(40);
    chk("rand_slots", bus.slots_issued, 40);
    chk("rand_out", bus.dma_outstanding, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
